// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and default frame/baud constants,
// common to the transmitter and the future receiver.
package uart_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   localparam int UART_B       = 8;
   localparam int UART_CLK_DIV = 16;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      START = ST_START,
      DATA  = ST_DATA,
      STOP  = ST_STOP
   } uart_tx_state_e;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port plus UART line and status, bundled between the FIFO drain
// logic (master) and the FIFO / pin side (slave).
interface fifo_uart_tx_if
   import uart_pkg::*;
#(
   parameter int B = UART_B
) ();

   logic         empty;
   logic [B-1:0] r_data;
   logic         rd;
   logic         tx;
   logic         busy;
   logic         tx_done_tick;

   modport master (
      input  empty, r_data,
      output rd, tx, busy, tx_done_tick
   );

   modport slave (
      output empty, r_data,
      input  rd, tx, busy, tx_done_tick
   );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts clk cycles within one UART bit and strobes
// bit_end in the last cycle of each bit. Cleared when a new frame is loaded.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int CLK_DIV = UART_CLK_DIV
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic bit_end
);

   localparam int             TW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [TW-1:0]  LAST_TICK = TW'(CLK_DIV - 1);

   logic [TW-1:0] tick_cnt;

   assign bit_end = en && (tick_cnt == LAST_TICK);

   // Count 0..CLK_DIV-1 while a frame is active, wrap at every bit boundary.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_cnt <= '0;
      end else if (clr || bit_end) begin
         tick_cnt <= '0;
      end else if (en) begin
         tick_cnt <= tick_cnt + TW'(1);
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining 8N1 UART transmitter. Latches the fall-through head word,
// pops it with a one-cycle rd pulse, and sends frames back to back while the
// FIFO holds data.
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int B       = UART_B,
   parameter int CLK_DIV = UART_CLK_DIV
) (
   input  logic            clk,
   input  logic            reset,
   fifo_uart_tx_if.master  bus
);

   localparam int            BW       = (B > 1) ? $clog2(B) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(B - 1);

   uart_tx_state_e state_q, state_d;
   logic [B-1:0]   shreg_q, shreg_d;
   logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
   logic           tx_q, tx_d;
   logic           rd_q;
   logic           load;
   logic           bit_end;
   logic           cnt_en;

   assign cnt_en = (state_q != IDLE);

   uart_baud_cnt #(
      .CLK_DIV (CLK_DIV)
   ) u_baud (
      .clk     (clk),
      .reset   (reset),
      .clr     (load),
      .en      (cnt_en),
      .bit_end (bit_end)
   );

   // Next-state, shift register and next line level; tx is registered so the
   // line level is computed for the state being entered.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      tx_d      = tx_q;
      load      = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (!bus.empty) begin
               load    = 1'b1;
               shreg_d = bus.r_data;
               state_d = START;
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_d   = DATA;
               bit_cnt_d = '0;
               tx_d      = shreg_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               shreg_d   = shreg_q >> 1;
               bit_cnt_d = bit_cnt_q + BW'(1);
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  tx_d = shreg_q[1];
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               if (!bus.empty) begin
                  // Next word already waiting: reload with no idle gap.
                  load    = 1'b1;
                  shreg_d = bus.r_data;
                  state_d = START;
                  tx_d    = 1'b0;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   // State, data and registered outputs; reset drops rd and returns the line high at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         tx_q      <= 1'b1;
         rd_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
         rd_q      <= load;
      end
   end

   assign bus.rd           = rd_q;
   assign bus.tx           = tx_q;
   assign bus.busy         = (state_q != IDLE);
   assign bus.tx_done_tick = (state_q == STOP) && bit_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a fall-through FIFO model and a
// mid-bit UART decoder for the random traffic scenario.
module tb_fifo_uart_tx;

   localparam int B     = 8;
   localparam int DIV   = 4;
   localparam int FRAME = (B + 2) * DIV;
   localparam int NRAND = 200;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [0:1023];
   int wr_ptr  = 0;
   int rd_ptr  = 0;
   int rd_cnt  = 0;
   int tk_cnt  = 0;
   int bad_rd  = 0;

   fifo_uart_tx_if #(.B(B)) bus ();

   assign bus.empty  = (wr_ptr == rd_ptr);
   assign bus.r_data = mem[rd_ptr[9:0]];

   fifo_uart_tx #(
      .B       (B),
      .CLK_DIV (DIV)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   // FIFO pops at the edge ending the rd cycle; also count pulses and ticks.
   always @(posedge clk) begin
      if (bus.rd) begin
         rd_ptr <= rd_ptr + 1;
         rd_cnt <= rd_cnt + 1;
      end
      if (bus.tx_done_tick) tk_cnt <= tk_cnt + 1;
      if (bus.rd && bus.empty) bad_rd <= bad_rd + 1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push(input logic [7:0] b);
      mem[wr_ptr[9:0]] = b;
      wr_ptr = wr_ptr + 1;
   endtask

   // Expected line level k cycles after the load edge for a frame carrying b.
   function automatic logic exp_tx(input logic [7:0] b, input int k);
      logic [9:0] fr;
      logic [9:0] sh;
      fr = {1'b1, b, 1'b0};
      sh = fr >> (k / DIV);
      return sh[0];
   endfunction

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(bus.busy === 1'b0 && bus.empty === 1'b1) && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 300) begin
         errors++;
         $display("FAIL wait_idle: busy=%b empty=%b after %0d cycles, required idle", bus.busy, bus.empty, n);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks += 4;
      if (bus.tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", bus.tx); end
      if (bus.rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", bus.rd); end
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      if (bus.tx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", bus.tx_done_tick); end
      reset = 1'b0;
      @(negedge clk);
      push(8'h5A);
      repeat (12) @(negedge clk);
      checks += 2;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL midframe_busy: got %b want 1", bus.busy); end
      if (rd_ptr !== wr_ptr) begin errors++; $display("FAIL midframe_popped: rd_ptr %0d want %0d", rd_ptr, wr_ptr); end
      reset = 1'b1;
      #1;
      checks += 4;
      if (bus.tx !== 1'b1) begin errors++; $display("FAIL async_tx: got %b want 1", bus.tx); end
      if (bus.rd !== 1'b0) begin errors++; $display("FAIL async_rd: got %b want 0", bus.rd); end
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b want 0", bus.busy); end
      if (bus.tx_done_tick !== 1'b0) begin errors++; $display("FAIL async_tick: got %b want 0", bus.tx_done_tick); end
      push(8'hC3);
      @(negedge clk);
      checks += 2;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL held_busy: got %b want 0", bus.busy); end
      if (bus.tx !== 1'b1) begin errors++; $display("FAIL held_tx: got %b want 1", bus.tx); end
      reset = 1'b0;
      #1;
      checks += 2;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL release_busy: got %b want 0", bus.busy); end
      if (bus.tx !== 1'b1) begin errors++; $display("FAIL release_tx: got %b want 1", bus.tx); end
      @(negedge clk);
      checks += 3;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL restart_busy: got %b want 1", bus.busy); end
      if (bus.tx !== 1'b0) begin errors++; $display("FAIL restart_tx: got %b want 0", bus.tx); end
      if (bus.rd !== 1'b1) begin errors++; $display("FAIL restart_rd: got %b want 1", bus.rd); end
      wait_idle();
   endtask

   task automatic test_single();
      int r0, t0;
      r0 = rd_cnt;
      t0 = tk_cnt;
      @(negedge clk);
      push(8'hA5);
      for (int k = 0; k < FRAME; k++) begin
         @(negedge clk);
         checks += 4;
         if (bus.tx !== exp_tx(8'hA5, k)) begin errors++; $display("FAIL single_tx k=%0d: got %b want %b", k, bus.tx, exp_tx(8'hA5, k)); end
         if (bus.rd !== (k == 0)) begin errors++; $display("FAIL single_rd k=%0d: got %b want %b", k, bus.rd, (k == 0)); end
         if (bus.tx_done_tick !== (k == FRAME - 1)) begin errors++; $display("FAIL single_tick k=%0d: got %b want %b", k, bus.tx_done_tick, (k == FRAME - 1)); end
         if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy k=%0d: got %b want 1", k, bus.busy); end
      end
      @(negedge clk);
      checks += 4;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_end_busy: got %b want 0", bus.busy); end
      if (bus.tx !== 1'b1) begin errors++; $display("FAIL single_end_tx: got %b want 1", bus.tx); end
      if (rd_cnt - r0 != 1) begin errors++; $display("FAIL single_rd_count: got %0d want 1", rd_cnt - r0); end
      if (tk_cnt - t0 != 1) begin errors++; $display("FAIL single_tick_count: got %0d want 1", tk_cnt - t0); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] w [3];
      int r0, t0;
      w[0] = 8'h00; w[1] = 8'hFF; w[2] = 8'h3C;
      r0 = rd_cnt;
      t0 = tk_cnt;
      @(negedge clk);
      for (int i = 0; i < 3; i++) push(w[i]);
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            checks += 4;
            if (bus.tx !== exp_tx(w[f], k)) begin errors++; $display("FAIL b2b_tx f=%0d k=%0d: got %b want %b", f, k, bus.tx, exp_tx(w[f], k)); end
            if (bus.rd !== (k == 0)) begin errors++; $display("FAIL b2b_rd f=%0d k=%0d: got %b want %b", f, k, bus.rd, (k == 0)); end
            if (bus.tx_done_tick !== (k == FRAME - 1)) begin errors++; $display("FAIL b2b_tick f=%0d k=%0d: got %b want %b", f, k, bus.tx_done_tick, (k == FRAME - 1)); end
            if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy f=%0d k=%0d: got %b want 1", f, k, bus.busy); end
         end
      end
      @(negedge clk);
      checks += 4;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_end_busy: got %b want 0", bus.busy); end
      if (bus.empty !== 1'b1) begin errors++; $display("FAIL b2b_end_empty: got %b want 1", bus.empty); end
      if (rd_cnt - r0 != 3) begin errors++; $display("FAIL b2b_rd_count: got %0d want 3", rd_cnt - r0); end
      if (tk_cnt - t0 != 3) begin errors++; $display("FAIL b2b_tick_count: got %0d want 3", tk_cnt - t0); end
   endtask

   task automatic test_empty_toggle();
      logic [7:0] b;
      @(negedge clk);
      push(8'h11);
      for (int k = 0; k < 2 * FRAME; k++) begin
         @(negedge clk);
         b = (k < FRAME) ? 8'h11 : 8'h22;
         checks += 3;
         if (bus.tx !== exp_tx(b, k % FRAME)) begin errors++; $display("FAIL toggle_tx k=%0d: got %b want %b", k, bus.tx, exp_tx(b, k % FRAME)); end
         if (bus.rd !== (k == 0 || k == FRAME)) begin errors++; $display("FAIL toggle_rd k=%0d: got %b want %b", k, bus.rd, (k == 0 || k == FRAME)); end
         if (bus.busy !== 1'b1) begin errors++; $display("FAIL toggle_busy k=%0d: got %b want 1", k, bus.busy); end
         if (k == 12) push(8'h22);
      end
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL toggle_end_busy: got %b want 0", bus.busy); end
   endtask

   task automatic test_underflow();
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         checks += 3;
         if (bus.rd !== 1'b0) begin errors++; $display("FAIL underflow_rd c=%0d: got %b want 0", c, bus.rd); end
         if (bus.tx !== 1'b1) begin errors++; $display("FAIL underflow_tx c=%0d: got %b want 1", c, bus.tx); end
         if (bus.busy !== 1'b0) begin errors++; $display("FAIL underflow_busy c=%0d: got %b want 0", c, bus.busy); end
      end
   endtask

   task automatic test_random();
      logic [7:0] sent [NRAND];
      logic [7:0] rec  [NRAND];
      int r0, t0;
      r0 = rd_cnt;
      t0 = tk_cnt;
      for (int i = 0; i < NRAND; i++) rec[i] = 8'h00;
      fork
         begin
            for (int i = 0; i < NRAND; i++) begin
               logic [7:0] v;
               repeat ($urandom_range(0, 50)) @(negedge clk);
               v = 8'($urandom_range(0, 255));
               sent[i] = v;
               push(v);
            end
         end
         begin
            for (int n = 0; n < NRAND; n++) begin
               int w;
               logic [7:0] d;
               w = 0;
               d = 8'h00;
               while (bus.tx !== 1'b0 && w < 3000) begin
                  @(negedge clk);
                  w++;
               end
               if (w >= 3000) begin
                  checks++;
                  errors++;
                  $display("FAIL random_timeout frame=%0d: no start bit within %0d cycles", n, w);
                  break;
               end
               repeat (DIV / 2) @(negedge clk);
               checks++;
               if (bus.tx !== 1'b0) begin errors++; $display("FAIL random_start frame=%0d: got %b want 0", n, bus.tx); end
               for (int i = 0; i < B; i++) begin
                  repeat (DIV) @(negedge clk);
                  d = {bus.tx, d[7:1]};
               end
               repeat (DIV) @(negedge clk);
               checks++;
               if (bus.tx !== 1'b1) begin errors++; $display("FAIL random_stop frame=%0d: got %b want 1", n, bus.tx); end
               rec[n] = d;
            end
         end
      join
      wait_idle();
      for (int i = 0; i < NRAND; i++) begin
         checks++;
         if (rec[i] !== sent[i]) begin errors++; $display("FAIL random_data i=%0d: got %02h want %02h", i, rec[i], sent[i]); end
      end
      checks += 3;
      if (rd_cnt - r0 != NRAND) begin errors++; $display("FAIL random_rd_count: got %0d want %0d", rd_cnt - r0, NRAND); end
      if (tk_cnt - t0 != NRAND) begin errors++; $display("FAIL random_tick_count: got %0d want %0d", tk_cnt - t0, NRAND); end
      if (bad_rd != 0) begin errors++; $display("FAIL rd_while_empty: got %0d want 0", bad_rd); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_empty_toggle();
      test_underflow();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
